// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usr_pkg
//  Description : Shared types for the universal shift register: the 2-bit
//                mode encoding driven by {S1,S0} and the sequencer states.
//  Revision    : 1.0  initial release
// ============================================================================
package usr_pkg;

   // Mode encoding matches {S1,S0} directly so the top can cast the pins.
   typedef enum logic [1:0] {
      USR_HOLD    = 2'b00,
      USR_SHL_MSB = 2'b01,
      USR_SHR_LSB = 2'b10,
      USR_LOAD    = 2'b11
   } usr_mode_e;

   typedef enum logic [0:0] {
      USR_IDLE = 1'b0,
      USR_RUN  = 1'b1
   } usr_state_e;

endpackage : usr_pkg
`default_nettype wire

// File: rtl/usr_shift_core.sv
`default_nettype none
// ============================================================================
//  Module      : usr_shift_core
//  Description : Purely combinational next-state datapath of the shift
//                register. Given the current contents and a mode, returns
//                the value the register takes on the next edge.
//  Ports       : q_i      current register contents
//                d_i      parallel load data
//                mode_i   hold / shift toward MSB / shift toward LSB / load
//                dsr_i    serial input entering bit 0 (shift toward MSB)
//                dsl_i    serial input entering bit WIDTH-1 (toward LSB)
//                rot_i    replace the serial input with the wrapped-out bit
//                q_next_o next register contents
//  Revision    : 1.0  initial release
// ============================================================================
module usr_shift_core
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   input  usr_mode_e        mode_i,
   input  logic             dsr_i,
   input  logic             dsl_i,
   input  logic             rot_i,
   output logic [WIDTH-1:0] q_next_o
);

   logic w_in_r;   // bit entering position 0
   logic w_in_l;   // bit entering position WIDTH-1

   // In rotate mode the bit leaving one end re-enters at the other end.
   assign w_in_r = rot_i ? q_i[WIDTH-1] : dsr_i;
   assign w_in_l = rot_i ? q_i[0]       : dsl_i;

   always_comb begin
      q_next_o = q_i;
      case (mode_i)
         USR_HOLD:    q_next_o = q_i;
         USR_SHL_MSB: q_next_o = {q_i[WIDTH-2:0], w_in_r};
         USR_SHR_LSB: q_next_o = {w_in_l, q_i[WIDTH-1:1]};
         USR_LOAD:    q_next_o = d_i;
         default:     q_next_o = q_i;
      endcase
   end

endmodule : usr_shift_core
`default_nettype wire

// File: rtl/universal_shift_register_n.sv
`default_nettype none
// ============================================================================
//  Module      : universal_shift_register_n
//  Description : WIDTH-bit bidirectional universal shift register with a
//                sequenced multi-step shift (START/CNT -> BUSY/DONE), serial
//                outputs at both ends and optional rotate.
//  Config      : define USR_ROTATE_EN to honour ROT (wrap-around shifting);
//                without it ROT is ignored and DSL/DSR are always used.
//  Ports       : CP     clock (rising edge)
//                CR     synchronous active-high reset
//                S1,S0  mode: 00 hold, 01 toward MSB, 10 toward LSB, 11 load
//                D      parallel load data
//                DSR    serial in at Q[0];   DSL serial in at Q[WIDTH-1]
//                ROT    rotate select
//                START  request CNT-step shift in direction S1,S0
//                CNT    number of steps
//                Q      register contents; SO_L = Q[WIDTH-1], SO_R = Q[0]
//                BUSY   multi-step shift in progress
//                DONE   one-cycle pulse after the final step
//  Revision    : 1.0  initial release
// ============================================================================
module universal_shift_register_n
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             CP,
   input  logic             CR,
   input  logic             S1,
   input  logic             S0,
   input  logic [WIDTH-1:0] D,
   input  logic             DSR,
   input  logic             DSL,
   input  logic             ROT,
   input  logic             START,
   input  logic [CNT_W-1:0] CNT,
   output logic [WIDTH-1:0] Q,
   output logic             SO_L,
   output logic             SO_R,
   output logic             BUSY,
   output logic             DONE
);

   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   usr_state_e       state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             dir_q, dir_d;     // 0: toward MSB, 1: toward LSB
   logic             rot_q, rot_d;     // latched rotate select for a run
   logic [CNT_W-1:0] rem_q, rem_d;     // shift steps still to perform
   logic             done_q, done_d;

   usr_mode_e        w_pin_mode;
   usr_mode_e        w_core_mode;
   logic             w_rot_in;
   logic             w_core_rot;
   logic [WIDTH-1:0] w_core_q;
   logic             w_start_ok;

   assign w_pin_mode = usr_mode_e'({S1, S0});

`ifdef USR_ROTATE_EN
   assign w_rot_in = ROT;
`else
   // Rotate is compiled out: ROT is tied off and the latched copy stays 0.
   logic w_unused_rot;
   assign w_unused_rot = ROT;
   assign w_rot_in     = 1'b0;
`endif

   // A run is only started for a real shift direction with a non-zero count;
   // any other START falls back to the ordinary single-cycle mode.
   assign w_start_ok = START && (CNT != '0) &&
                       ((w_pin_mode == USR_SHL_MSB) || (w_pin_mode == USR_SHR_LSB));

   usr_shift_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .q_i      (q_q),
      .d_i      (D),
      .mode_i   (w_core_mode),
      .dsr_i    (DSR),
      .dsl_i    (DSL),
      .rot_i    (w_core_rot),
      .q_next_o (w_core_q)
   );

   always_comb begin
      state_d     = state_q;
      q_d         = q_q;
      dir_d       = dir_q;
      rot_d       = rot_q;
      rem_d       = rem_q;
      done_d      = 1'b0;
      w_core_mode = w_pin_mode;
      w_core_rot  = w_rot_in;

      case (state_q)
         USR_IDLE: begin
            if (w_start_ok) begin
               // Accepting edge: latch the run, register contents unchanged.
               state_d = USR_RUN;
               dir_d   = (w_pin_mode == USR_SHR_LSB);
               rot_d   = w_rot_in;
               rem_d   = CNT;
            end else begin
               q_d = w_core_q;
            end
         end
         USR_RUN: begin
            // Pins other than the serial inputs are ignored while running.
            w_core_mode = dir_q ? USR_SHR_LSB : USR_SHL_MSB;
            w_core_rot  = rot_q;
            q_d         = w_core_q;
            rem_d       = rem_q - C_ONE;
            if (rem_q == C_ONE) begin
               state_d = USR_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = USR_IDLE;
         end
      endcase
   end

   always_ff @(posedge CP) begin
      if (CR) begin
         state_q <= USR_IDLE;
         q_q     <= '0;
         dir_q   <= 1'b0;
         rot_q   <= 1'b0;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         dir_q   <= dir_d;
         rot_q   <= rot_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end

   assign Q    = q_q;
   assign SO_L = q_q[WIDTH-1];
   assign SO_R = q_q[0];
   assign BUSY = (state_q == USR_RUN);
   assign DONE = done_q;

endmodule : universal_shift_register_n
`default_nettype wire

// File: tb/tb_universal_shift_register_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_universal_shift_register_n
//  Description : Directed self-checking bench for universal_shift_register_n
//                (WIDTH=8, CNT_W=4) with hand-computed expected values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_universal_shift_register_n;

   logic       CP = 1'b0;
   logic       CR, S1, S0, DSR, DSL, ROT, START;
   logic [7:0] D;
   logic [3:0] CNT;
   logic [7:0] Q;
   logic       SO_L, SO_R, BUSY, DONE;

   int n_total = 0;
   int n_bad   = 0;
   int busy_cycles;

   universal_shift_register_n #(
      .WIDTH (8),
      .CNT_W (4)
   ) dut (
      .CP    (CP),
      .CR    (CR),
      .S1    (S1),
      .S0    (S0),
      .D     (D),
      .DSR   (DSR),
      .DSL   (DSL),
      .ROT   (ROT),
      .START (START),
      .CNT   (CNT),
      .Q     (Q),
      .SO_L  (SO_L),
      .SO_R  (SO_R),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   always #5 CP = ~CP;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock edge; outputs are examined 1 time unit after it.
   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   // Called right after the START edge; counts cycles with BUSY high.
   task automatic run_to_end(output int cycles);
      cycles = 0;
      for (int g = 0; g < 40; g++) begin
         if (!BUSY) break;
         cycles++;
         tick();
      end
   endtask

   task automatic set_mode(input logic [1:0] m);
      {S1, S0} = m;
   endtask

   task automatic load(input logic [7:0] v);
      START = 1'b0;
      set_mode(2'b11);
      D = v;
      tick();
      set_mode(2'b00);
   endtask

   initial begin
      CR = 1'b1; S1 = 0; S0 = 0; D = '0; DSR = 0; DSL = 0; ROT = 0;
      START = 0; CNT = '0;
      tick();
      CR = 1'b0;

      // 1. reset overrides a START
      load(8'hA5);
      chk("load_a5", Q, 8'hA5);
      CR = 1'b1; START = 1'b1; set_mode(2'b01); CNT = 4'd3;
      tick();
      CR = 1'b0; START = 1'b0; set_mode(2'b00);
      chk("rst_q", Q, 8'h00);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);

      // 2. single-cycle modes
      load(8'h96);
      chk("load_96", Q, 8'h96);
      set_mode(2'b01); DSR = 1'b1; tick();
      chk("shl_q", Q, 8'h2D);
      chk("shl_sol", SO_L, 1'b0);
      chk("shl_sor", SO_R, 1'b1);
      set_mode(2'b10); DSL = 1'b0; tick();
      chk("shr_q", Q, 8'h16);
      set_mode(2'b00); tick();
      chk("hold_q", Q, 8'h16);

      // 3. three-step shift toward MSB
      load(8'h81);
      set_mode(2'b01); DSR = 1'b0; START = 1'b1; CNT = 4'd3;
      tick();
      START = 1'b0; set_mode(2'b00);
      chk("run3_start_q", Q, 8'h81);
      chk("run3_start_busy", BUSY, 1'b1);
      run_to_end(busy_cycles);
      chk("run3_busy_len", busy_cycles, 3);
      chk("run3_q", Q, 8'h08);
      chk("run3_done", DONE, 1'b1);
      tick();
      chk("run3_done_clr", DONE, 1'b0);

      // 4. pins ignored during a run
      load(8'h81);
      set_mode(2'b10); DSL = 1'b1; START = 1'b1; CNT = 4'd3;
      tick();
      set_mode(2'b11); D = 8'hFF; CNT = 4'd7;
      run_to_end(busy_cycles);
      chk("ign_busy_len", busy_cycles, 3);
      chk("ign_q", Q, 8'hF0);
      chk("ign_done", DONE, 1'b1);
      START = 1'b0; set_mode(2'b00);
      tick();
      chk("ign_q_after", Q, 8'hF0);

      // 5. reset mid-run, then a fresh run
      set_mode(2'b01); DSR = 1'b1; START = 1'b1; CNT = 4'd5;
      tick();
      START = 1'b0; set_mode(2'b00);
      tick(); tick();
      chk("mid_q", Q, 8'hC3);
      CR = 1'b1; tick(); CR = 1'b0;
      chk("mid_rst_q", Q, 8'h00);
      chk("mid_rst_busy", BUSY, 1'b0);
      chk("mid_rst_done", DONE, 1'b0);
      tick();
      chk("mid_rst_done2", DONE, 1'b0);
      set_mode(2'b01); DSR = 1'b1; START = 1'b1; CNT = 4'd2;
      tick();
      START = 1'b0; set_mode(2'b00);
      chk("restart_busy", BUSY, 1'b1);
      run_to_end(busy_cycles);
      chk("restart_len", busy_cycles, 2);
      chk("restart_q", Q, 8'h03);

      // CNT greater than WIDTH, then a back-to-back run while DONE is high
      set_mode(2'b10); DSL = 1'b1; START = 1'b1; CNT = 4'd10;
      tick();
      START = 1'b0; set_mode(2'b00);
      run_to_end(busy_cycles);
      chk("long_len", busy_cycles, 10);
      chk("long_q", Q, 8'hFF);
      chk("long_done", DONE, 1'b1);
      set_mode(2'b01); DSR = 1'b0; START = 1'b1; CNT = 4'd1;
      tick();
      START = 1'b0; set_mode(2'b00);
      chk("b2b_busy", BUSY, 1'b1);
      chk("b2b_q0", Q, 8'hFF);
      run_to_end(busy_cycles);
      chk("b2b_len", busy_cycles, 1);
      chk("b2b_q", Q, 8'hFE);

      // START with CNT=0 is a plain single-cycle shift
      set_mode(2'b01); DSR = 1'b1; START = 1'b1; CNT = 4'd0;
      tick();
      START = 1'b0; set_mode(2'b00);
      chk("cnt0_q", Q, 8'hFD);
      chk("cnt0_busy", BUSY, 1'b0);

      // 6. rotate (behaviour depends on build configuration)
      load(8'h81);
      set_mode(2'b10); DSL = 1'b0; ROT = 1'b1; START = 1'b1; CNT = 4'd1;
      tick();
      START = 1'b0; ROT = 1'b0; set_mode(2'b00);
      run_to_end(busy_cycles);
`ifdef USR_ROTATE_EN
      chk("rot_run_q", Q, 8'hC0);
`else
      chk("rot_run_q", Q, 8'h40);
`endif
      load(8'h81);
      set_mode(2'b01); DSR = 1'b0; ROT = 1'b1;
      tick();
      ROT = 1'b0; set_mode(2'b00);
`ifdef USR_ROTATE_EN
      chk("rot_idle_q", Q, 8'h03);
`else
      chk("rot_idle_q", Q, 8'h02);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_universal_shift_register_n
`default_nettype wire
